// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the chunked, pipelined adder/subtractor.
// Width helpers keep the stage slicing arithmetic in one place.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Stage register layout for the default configuration.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 sub;
        logic [DEF_WIDTH-1:0] psum;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
    } stage_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } result_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The last stage keeps only the operand MSBs, which the overflow flag needs.
    function automatic int rem_out_width(input int width, input int stages, input int idx);
        return (idx == stages - 1) ? 1 : width - (idx + 1) * (width / stages);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
interface pipe_adder_if #(
    parameter int WIDTH = pipe_adder_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder_stage.sv
// One CHUNK-wide slice of the pipelined adder: adds its chunk, appends it to the
// finished low bits, and forwards the untouched operand chunks downstream.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int STAGES = DEF_STAGES,
    parameter  int IDX    = 0,
    localparam int CHUNK  = chunk_width(WIDTH, STAGES),
    localparam int LIN_W  = IDX * CHUNK + 1,
    localparam int RIN_W  = WIDTH - IDX * CHUNK,
    localparam int LOUT_W = LIN_W + CHUNK,
    localparam int ROUT_W = rem_out_width(WIDTH, STAGES, IDX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_next_load,
    input  logic              i_valid,
    input  logic              i_sub,
    input  logic [LIN_W-1:0]  i_low,
    input  logic [RIN_W-1:0]  i_a_rem,
    input  logic [RIN_W-1:0]  i_b_rem,
    output logic              o_load,
    output logic              o_valid,
    output logic              o_sub,
    output logic [LOUT_W-1:0] o_low,
    output logic [ROUT_W-1:0] o_a_rem,
    output logic [ROUT_W-1:0] o_b_rem
);

    logic              r_valid;
    logic              r_sub;
    logic [LOUT_W-1:0] r_low;
    logic [ROUT_W-1:0] r_a_rem;
    logic [ROUT_W-1:0] r_b_rem;

    logic [CHUNK-1:0]  w_b_eff;
    logic [CHUNK:0]    w_chunk_sum;
    logic [LOUT_W-1:0] w_low_next;
    logic [ROUT_W-1:0] w_a_next;
    logic [ROUT_W-1:0] w_b_next;

    // i_low carries {carry, finished low bits}; its MSB is this chunk's carry-in.
    assign w_b_eff     = i_b_rem[CHUNK-1:0] ^ {CHUNK{i_sub}};
    assign w_chunk_sum = {1'b0, i_a_rem[CHUNK-1:0]} + {1'b0, w_b_eff}
                       + {{CHUNK{1'b0}}, i_low[LIN_W-1]};

    generate
        if (IDX == 0) begin : g_first
            assign w_low_next = w_chunk_sum;
        end else begin : g_chain
            assign w_low_next = {w_chunk_sum, i_low[LIN_W-2:0]};
        end

        if (IDX == STAGES - 1) begin : g_last
            assign w_a_next = i_a_rem[RIN_W-1];
            assign w_b_next = i_b_rem[RIN_W-1];
        end else begin : g_mid
            assign w_a_next = i_a_rem[RIN_W-1:CHUNK];
            assign w_b_next = i_b_rem[RIN_W-1:CHUNK];
        end
    endgenerate

    assign o_load = !r_valid || i_next_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sub   <= 1'b0;
            r_low   <= '0;
            r_a_rem <= '0;
            r_b_rem <= '0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sub   <= i_sub;
                r_low   <= w_low_next;
                r_a_rem <= w_a_next;
                r_b_rem <= w_b_next;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sub   = r_sub;
    assign o_low   = r_low;
    assign o_a_rem = r_a_rem;
    assign o_b_rem = r_b_rem;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: STAGES chunk slices in series with a ready/valid
// handshake on both ends; load enables ripple back from out_ready.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  s_bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LIN_W  = gi * CHUNK + 1;
            localparam int RIN_W  = WIDTH - gi * CHUNK;
            localparam int LOUT_W = LIN_W + CHUNK;
            localparam int ROUT_W = rem_out_width(WIDTH, STAGES, gi);

            logic              w_in_valid;
            logic              w_in_sub;
            logic              w_next_load;
            logic [LIN_W-1:0]  w_in_low;
            logic [RIN_W-1:0]  w_in_a;
            logic [RIN_W-1:0]  w_in_b;
            logic              w_load;
            logic              w_valid;
            logic              w_sub;
            logic [LOUT_W-1:0] w_low;
            logic [ROUT_W-1:0] w_a;
            logic [ROUT_W-1:0] w_b;

            if (gi == 0) begin : g_head
                // Subtract forces carry-in to 1 so that a + ~b + 1 = a - b.
                assign w_in_valid = s_bus.in_valid;
                assign w_in_sub   = s_bus.sub;
                assign w_in_low   = s_bus.sub | s_bus.cin;
                assign w_in_a     = s_bus.a;
                assign w_in_b     = s_bus.b;
            end else begin : g_link
                assign w_in_valid = g_stage[gi-1].w_valid;
                assign w_in_sub   = g_stage[gi-1].w_sub;
                assign w_in_low   = g_stage[gi-1].w_low;
                assign w_in_a     = g_stage[gi-1].w_a;
                assign w_in_b     = g_stage[gi-1].w_b;
            end

            if (gi == STAGES - 1) begin : g_tail
                assign w_next_load = s_bus.out_ready;
            end else begin : g_body
                assign w_next_load = g_stage[gi+1].w_load;
            end

            pipe_adder_stage #(
                .WIDTH  (WIDTH),
                .STAGES (STAGES),
                .IDX    (gi)
            ) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_next_load (w_next_load),
                .i_valid     (w_in_valid),
                .i_sub       (w_in_sub),
                .i_low       (w_in_low),
                .i_a_rem     (w_in_a),
                .i_b_rem     (w_in_b),
                .o_load      (w_load),
                .o_valid     (w_valid),
                .o_sub       (w_sub),
                .o_low       (w_low),
                .o_a_rem     (w_a),
                .o_b_rem     (w_b)
            );
        end
    endgenerate

    logic w_a_msb;
    logic w_b_eff_msb;
    logic w_sum_msb;

    assign w_a_msb     = g_stage[LAST].w_a[0];
    assign w_b_eff_msb = g_stage[LAST].w_b[0] ^ g_stage[LAST].w_sub;
    assign w_sum_msb   = g_stage[LAST].w_low[WIDTH-1];

    assign s_bus.in_ready  = g_stage[0].w_load;
    assign s_bus.out_valid = g_stage[LAST].w_valid;
    assign s_bus.sum       = g_stage[LAST].w_low[WIDTH-1:0];
    assign s_bus.cout      = g_stage[LAST].w_low[WIDTH];
    // Derived only from last-stage registers, so it holds steady under backpressure.
    assign s_bus.ovf       = (w_a_msb == w_b_eff_msb) && (w_sum_msb != w_a_msb);

endmodule
